// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified memory shared by the IF and MEM stages.
// Sequences IDLE -> ACCESS x MEM_LAT -> RESP, data-first with a bounded data streak.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] CntInit   = 4'(MEM_LAT - 1);
  localparam logic [1:0] StreakMax = 2'(MAX_D_STREAK);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        d_streak_q, d_streak_d;
  logic              owner_d_q, owner_d_d;  // 1: data port owns the access
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d;

  // Data wins unless the fetch has already waited out the streak limit.
  assign grant_d = d_req & (~if_req | (d_streak_q != StreakMax));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_streak_d  = d_streak_q;
    owner_d_d   = owner_d_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          owner_d_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          cnt_d       = CntInit;
          state_d     = StAccess;
          if (!if_req) begin
            d_streak_d = 2'd0;
          end else if (d_streak_q != StreakMax) begin
            d_streak_d = d_streak_q + 2'd1;
          end
        end else if (if_req) begin
          owner_d_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          cnt_d      = CntInit;
          d_streak_d = 2'd0;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!mem_we_q) begin
            if (owner_d_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
          state_d = StResp;
        end
      end
      StResp: begin
        // Never start a new access here, so a still-high req is not served twice.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      d_streak_q  <= 2'd0;
      owner_d_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_streak_q  <= d_streak_d;
      owner_d_q   <= owner_d_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = (state_q == StResp) & ~owner_d_q;
  assign d_ack     = (state_q == StResp) & owner_d_q;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle checks plus an ack-driven rdata scoreboard
// against a small behavioural memory.
module tb_mem_port_arbiter;

  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned MemLat = 2;
  localparam int unsigned MaxDs  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_req, d_req, d_we;
  logic [AddrW-1:0] if_addr, d_addr;
  logic [DataW-1:0] d_wdata;
  logic [DataW-1:0] if_rdata, d_rdata;
  logic             if_ack, d_ack;
  logic             mem_en, mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata, mem_rdata;
  logic             stall_if, stall_mem;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DataW-1:0] if_exp_q[$];
  logic [DataW-1:0] d_exp_q[$];
  logic [DataW-1:0] last_d_rd;

  bit [DataW-1:0] wmem [256];
  bit             wset [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (AddrW),
    .DATA_W       (DataW),
    .MEM_LAT      (MemLat),
    .MAX_D_STREAK (MaxDs)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  function automatic logic [DataW-1:0] mem_init(input logic [AddrW-1:0] a);
    if (a == 32'h4) return 32'h8C01_0000;
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  function automatic logic [DataW-1:0] model_rd(input logic [AddrW-1:0] a);
    if (wset[a[9:2]]) return wmem[a[9:2]];
    return mem_init(a);
  endfunction

  // Behavioural memory: combinational read while enabled, write on the edge.
  always_comb begin
    mem_rdata = '0;
    if (mem_en) begin
      mem_rdata = wset[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : mem_init(mem_addr);
    end
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr[9:2]] <= mem_wdata;
      wset[mem_addr[9:2]] <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack pops the rdata expected for that requester.
  always @(negedge clk) begin
    if (if_ack) begin
      if (if_exp_q.size() == 0) check_eq("if_ack_unexpected", 32'd1, 32'd0);
      else check_eq("sb_if_rdata", if_rdata, if_exp_q.pop_front());
    end
    if (d_ack) begin
      if (d_exp_q.size() == 0) check_eq("d_ack_unexpected", 32'd1, 32'd0);
      else check_eq("sb_d_rdata", d_rdata, d_exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] order;
    int         n_acks;

    rst_n   = 1'b0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    if_addr = '0;
    d_addr  = '0;
    d_wdata = '0;
    last_d_rd = '0;

    // Power-up reset values
    repeat (2) @(posedge clk);
    smp();
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_acks", 32'({if_ack, d_ack}), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_stalls", 32'({stall_if, stall_mem}), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single fetch
    if_req  = 1'b1;
    if_addr = 32'h04;
    if_exp_q.push_back(32'h8C01_0000);
    for (int c = 0; c <= 3; c++) begin
      smp();
      check_eq($sformatf("t1_mem_en_c%0d", c), 32'(mem_en), 32'(c == 1 || c == 2));
      if (c == 1 || c == 2) check_eq($sformatf("t1_mem_addr_c%0d", c), mem_addr, 32'h04);
      check_eq($sformatf("t1_if_ack_c%0d", c), 32'(if_ack), 32'(c == 3));
      check_eq($sformatf("t1_stall_if_c%0d", c), 32'(stall_if), 32'(c < 3));
      if (c == 3) begin
        check_eq("t1_if_rdata", if_rdata, 32'h8C01_0000);
        if_req = 1'b0;
      end
      cyc();
    end

    // Simultaneous fetch and load
    if_req  = 1'b1;
    if_addr = 32'h08;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h100;
    d_exp_q.push_back(model_rd(32'h100));
    if_exp_q.push_back(model_rd(32'h08));
    last_d_rd = model_rd(32'h100);
    for (int c = 0; c <= 7; c++) begin
      smp();
      check_eq($sformatf("t2_mem_en_c%0d", c), 32'(mem_en),
               32'(c == 1 || c == 2 || c == 5 || c == 6));
      if (c == 5 || c == 6) check_eq($sformatf("t2_mem_addr_c%0d", c), mem_addr, 32'h08);
      check_eq($sformatf("t2_d_ack_c%0d", c), 32'(d_ack), 32'(c == 3));
      check_eq($sformatf("t2_if_ack_c%0d", c), 32'(if_ack), 32'(c == 7));
      check_eq($sformatf("t2_stall_if_c%0d", c), 32'(stall_if), 32'(c < 7));
      if (c == 3) d_req = 1'b0;
      if (c == 7) if_req = 1'b0;
      cyc();
    end

    // Store must not disturb d_rdata
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h200;
    d_wdata = 32'hDEAD_BEEF;
    d_exp_q.push_back(last_d_rd);
    for (int c = 0; c <= 3; c++) begin
      smp();
      if (c == 1 || c == 2) begin
        check_eq($sformatf("t3_en_we_c%0d", c), 32'({mem_en, mem_we}), 32'd3);
        check_eq($sformatf("t3_wdata_c%0d", c), mem_wdata, 32'hDEAD_BEEF);
      end
      check_eq($sformatf("t3_d_ack_c%0d", c), 32'(d_ack), 32'(c == 3));
      if (c == 3) begin
        check_eq("t3_d_rdata_kept", d_rdata, last_d_rd);
        d_req = 1'b0;
        d_we  = 1'b0;
      end
      cyc();
    end
    check_eq("t3_mem_written", model_rd(32'h200), 32'hDEAD_BEEF);

    // Starvation limit: expect D, D, IF, D, D, IF
    if_req = 1'b1;
    if_addr = 32'h0C;
    d_req  = 1'b1;
    d_addr = 32'h104;
    for (int i = 0; i < 4; i++) d_exp_q.push_back(model_rd(32'h104));
    for (int i = 0; i < 2; i++) if_exp_q.push_back(model_rd(32'h0C));
    last_d_rd = model_rd(32'h104);
    order  = '0;
    n_acks = 0;
    for (int k = 0; k < 6 * (MemLat + 2) + 8 && n_acks < 6; k++) begin
      smp();
      if (d_ack) begin
        order = {order[4:0], 1'b1};
        n_acks++;
      end
      if (if_ack) begin
        order = {order[4:0], 1'b0};
        n_acks++;
      end
      if (n_acks == 6) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      cyc();
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check_eq("t4_ack_count", n_acks, 6);
    check_eq("t4_grant_order", 32'(order), 32'h36);
    cyc();

    // Reset in the middle of a fetch
    if_req  = 1'b1;
    if_addr = 32'h10;
    if_exp_q.push_back(model_rd(32'h10));
    cyc();
    smp();
    check_eq("t5_mem_en_c1", 32'(mem_en), 32'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    check_eq("t5_mem_en_async", 32'(mem_en), 32'd0);
    for (int c = 0; c < 2; c++) begin
      smp();
      check_eq($sformatf("t5_no_ack_%0d", c), 32'({if_ack, d_ack}), 32'd0);
      check_eq($sformatf("t5_mem_en_%0d", c), 32'(mem_en), 32'd0);
      check_eq($sformatf("t5_stall_if_%0d", c), 32'(stall_if), 32'd1);
      cyc();
    end
    check_eq("t5_rst_mem_addr", mem_addr, 32'd0);
    check_eq("t5_rst_d_rdata", d_rdata, 32'd0);
    last_d_rd = '0;
    rst_n = 1'b1;
    for (int k = 0; k <= int'(MemLat) + 1; k++) begin
      smp();
      check_eq($sformatf("t5_if_ack_k%0d", k), 32'(if_ack), 32'(k == int'(MemLat) + 1));
      if (k == int'(MemLat) + 1) if_req = 1'b0;
      cyc();
    end

    // Address change during the access is ignored
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h100;
    d_exp_q.push_back(model_rd(32'h100));
    for (int c = 0; c <= 3; c++) begin
      if (c == 1) d_addr = 32'h300;
      smp();
      if (c == 1 || c == 2) check_eq($sformatf("t6_mem_addr_c%0d", c), mem_addr, 32'h100);
      check_eq($sformatf("t6_d_ack_c%0d", c), 32'(d_ack), 32'(c == 3));
      check_eq($sformatf("t6_stall_mem_c%0d", c), 32'(stall_mem), 32'(c < 3));
      if (c == 3) begin
        check_eq("t6_d_rdata", d_rdata, model_rd(32'h100));
        d_req = 1'b0;
      end
      cyc();
    end

    repeat (3) cyc();
    check_eq("if_queue_drained", if_exp_q.size(), 32'd0);
    check_eq("d_queue_drained", d_exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory of the MIPS pipeline between the IF stage (instruction fetch) and the MEM stage (lw/sw). It sequences multi-cycle memory accesses and grants data accesses priority over fetches, with an anti-starvation limit. It returns per-requester acknowledges and stall signals that freeze the IF and MEM pipeline stages while their access is pending.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles the memory needs per access with mem_en and address held stable; legal values are 1 to 15
- MAX_D_STREAK, 2, maximum consecutive data grants while if_req is pending; legal values are 1 to 3

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request; level, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid with if_ack, held until the next fetch completes
- if_ack  out  1  one-cycle completion pulse for the fetch
- d_req  in  1  data request; level, held until d_ack
- d_we  in  1  1 = sw (write), 0 = lw (read)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid with d_ack; updated only by reads
- d_ack  out  1  one-cycle completion pulse for the data access
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last access cycle
- stall_if  out  1  equals if_req & ~if_ack (combinational)
- stall_mem  out  1  equals d_req & ~d_ack (combinational)

## Operation
- FSM states:
  - IDLE: mem_en=0. Requests are sampled at the edge. The chosen request's addr, we and wdata are latched, owner is recorded, cnt is set to MEM_LAT-1, and the FSM moves to ACCESS. If there is no request it stays in IDLE.
  - ACCESS: mem_en=1; mem_we is the latched we (0 for fetch); mem_addr and mem_wdata come from the latched registers. At the edge, if cnt>0, decrement cnt. If cnt==0, capture mem_rdata into the owner's rdata register (skipped for writes) and move to RESP.
  - RESP: mem_en=0; the owner's ack=1. Always returns to IDLE and never starts an access, so a request still high in its ack cycle is not double-served.
- Arbitration in IDLE:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both requests: grant D, unless d_streak==MAX_D_STREAK, in which case grant IF.
- d_streak counter:
  - Increments on a D grant while if_req=1; saturates at MAX_D_STREAK.
  - Clears on an IF grant.
  - Clears on a D grant while if_req=0.
- Input changes during ACCESS or RESP are ignored because the latched copies drive the memory.
- The latched mem_addr, mem_wdata and mem_we registers keep their last values in IDLE and RESP; only mem_en drops.
- Reset: asynchronous assertion forces IDLE and aborts any access in progress with no ack. Outputs at reset:
  - mem_en, mem_we, if_ack, d_ack are 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata are 0.
  - d_streak and cnt are 0.
  - stall outputs follow the req inputs.
  - Requesters keep their req high, so the request is re-sampled after release.

## Timing
- Cycle numbering: a request sampled at the end of cycle 0 gives ACCESS in cycles 1 through MEM_LAT and ack in cycle MEM_LAT+1.
- Request-to-ack latency is MEM_LAT+1 cycles when the memory is free.
- Throughput is one access per MEM_LAT+2 cycles. This is the IDLE, ACCESS×MEM_LAT, RESP sequence when requests are back-to-back.
- Ack is registered and lasts exactly one cycle. The rdata value is stable from the ack cycle until that requester's next completion.
- Stall is combinational: it is high from the cycle req rises through the cycle before ack, and low in the ack cycle.

## Test plan
- **Single fetch** (MEM_LAT=2): if_req=1, if_addr=0x04 in cycle 0, memory returns 0x8C010000. Required: mem_en=1 and mem_addr=0x04 in cycles 1–2; if_ack=1 and if_rdata=0x8C010000 in cycle 3; stall_if=1 in cycles 0–2.
- **Simultaneous requests**: if_req and d_req (lw, 0x100) both rise in cycle 0. Required: d_ack in cycle 3; IF granted at the end of cycle 4, mem_addr=if_addr in cycles 5–6, if_ack in cycle 7; stall_if stays high through cycle 6.
- **Store**: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF. Required: mem_en=mem_we=1 and mem_wdata=0xDEADBEEF in cycles 1–2; d_ack in cycle 3; d_rdata unchanged.
- **Starvation limit** (MAX_D_STREAK=2): d_req re-asserted continuously with if_req held high. Required grant order is D, D, IF, D, D, IF.
- **Reset mid-access**: rst_n=0 during cycle 2 of a fetch. Required: mem_en=0 immediately and no if_ack. After rst_n returns to 1 with if_req still high, if_ack arrives MEM_LAT+1 cycles after the first sampling edge.
- **Input change during access**: d_addr changes from 0x100 to 0x300 in cycle 1. Required: mem_addr stays 0x100 through cycle 2, and d_rdata equals the data read at 0x100.
